csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Parametrised machine-mode CSR file and interrupt controller for the single-issue RV32 core; successor to the timer-only CSR block.
- Adds:
  - full CSR op decode (RW/RS/RC, immediate forms via wdata)
  - per-address writes
  - three prioritised interrupt sources
  - trap entry with mepc/mcause capture
  - MIE/MPIE stacking, and a direct or vectored mtvec.
- Sits beside the register file in the execute stage; drives the PC-redirect mux.

Parameters:
- XLEN, 32, data/CSR width.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- VECTORED_EN, 1, 1 = honour mtvec.MODE=1 (vectored); 0 = force direct mode, MODE bits read 0.
- IRQ_SYNC, 1, 1 = register the external/timer interrupt inputs one cycle before mip; 0 = feed them to mip directly.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- addr  in  12  CSR address from inst[31:20]
- wdata  in  XLEN  rs1 value or zero-extended uimm
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_rd  in  1  read enable
- pc  in  XLEN  PC of the instruction in execute
- inst_valid  in  1  an instruction occupies execute and may be trapped
- is_mret  in  1  mret in execute
- tm_interupt  in  1  timer interrupt level (MTIP)
- ext_interupt  in  1  external interrupt level (MEIP)
- rdata  out  XLEN  CSR read data
- epc  out  XLEN  mret target (= mepc)
- epc_taken  out  1  mret redirect this cycle
- excep  out  1  trap taken this cycle (redirect to trap_pc)
- trap_pc  out  XLEN  handler address
- in_handler  out  1  FSM in HANDLER state

Behaviour:

Implemented CSRs (others read 0, writes ignored):
- mstatus 0x300: bits 3 MIE and 7 MPIE are writable; the rest read 0.
- mie 0x304: bits 3, 7, 11 are writable.
- mtvec 0x305: MODE[1:0] is WARL in {0,1}.
- mscratch 0x340.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342.
- mip 0x344: only MSIP (bit 3) is writable. MTIP (bit 7) and MEIP (bit 11) are read-only and follow the inputs, with one cycle of latency when IRQ_SYNC=1.

Reset (rst=1 at posedge): all CSRs 0 except mtvec=MTVEC_RST. FSM returns to RUN. Outputs at reset: excep=0, epc_taken=0, in_handler=0, rdata=0, epc=0, trap_pc=MTVEC_RST base.

CSR read:
- rdata is combinational: the old CSR value when csr_rd=1, otherwise 0.

CSR write (at posedge, when csr_op!=00 and no trap is taken that cycle):
- new = RW: wdata; RS: old|wdata; RC: old&~wdata.
- The value is then masked to the writable bits.
- RS/RC with wdata=0 performs no write.

Interrupt arbitration:
- pend = mstatus.MIE & (mie & mip).
- Priority: MEI(11) > MSI(3) > MTI(7).

Trap entry, when |pend & inst_valid (combinational excep=1). At the next edge:
- mepc <= pc
- mcause <= {1'b1, code}
- MPIE <= MIE, MIE <= 0
- FSM -> HANDLER
- trap_pc = base when MODE=0; base + 4*code when MODE=1 and VECTORED_EN=1.

mret (is_mret & inst_valid & no trap):
- epc_taken=1 and epc=mepc, both combinational.
- At the edge: MIE <= MPIE, MPIE <= 1, FSM -> RUN.

FSM:
- RUN --trap--> HANDLER --mret--> RUN.
- HANDLER blocks nothing by itself; nesting is prevented because MIE=0. A trap taken while in HANDLER (MIE re-enabled by software) stays in HANDLER.

Simultaneous events:
- trap + mret: the trap wins and mepc <= pc of the mret.
- trap + CSR write: the write is dropped and the instruction is re-executed after return.
- mret + CSR write to mstatus: mret's update wins.
- The inputs are level-sensitive. Software clears the source (timer compare or MSIP write); mip itself is never auto-cleared by a trap.

Decomposition:
- csr_pkg holds:
  - the CSR address constants
  - the csr_op enum
  - cause codes (3, 7, 11)
  - mstatus bit indices
  - writable-bit masks
  - the FSM state enum.
- Sub-module csr_irq_arb: combinational fixed-priority encoder. Inputs are pend[11:0]; outputs are irq_valid and code[3:0].

Test Plan:
1. Reset, then read all CSRs -> all 0 and mtvec=MTVEC_RST; excep=0, in_handler=0.
2. csrrw 0x305 with 0x0000_1001, then csrrs 0x304 with 0x80, then csrrs 0x300 with 0x8; raise tm_interupt with pc=0x40 -> after the sync cycle, excep=1, trap_pc=0x101C; next cycle mepc=0x40, mcause=0x8000_0007, MIE=0, MPIE=1, in_handler=1.
3. With the state from scenario 2, apply is_mret -> epc_taken=1, epc=0x40; next cycle MIE=1, MPIE=1, in_handler=0.
4. mie=0x888, MIE=1, both ext_interupt and tm_interupt high, plus csrrs mip 0x8 -> mcause=0x8000_000B and trap_pc=base+0x2C; the MSIP write is dropped.
5. csrrc 0x300 with 0x8 in the same cycle as a pending interrupt -> the trap is taken, mstatus is not cleared by the write, and mepc equals the pc of the csrrc.
6. Assert rst while in HANDLER with the interrupt inputs held high -> next cycle in_handler=0, MIE=0, excep=0 (masked), mepc=0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file and its interrupt arbiter.
package csr_pkg;

    // Implemented CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // CSR instruction operation (immediate forms arrive already zero-extended on wdata)
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Interrupt cause codes; also the bit positions in mie/mip
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // mstatus bit indices
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // Software-writable bits of the masked CSRs
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MIP_WMASK     = 32'h0000_0008;

    // Trap FSM: RUN until a trap is taken, HANDLER until mret
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } csr_state_e;

endpackage

// File: rtl/csr_irq_arb.sv
// Fixed-priority interrupt encoder: MEI (11) beats MSI (3) beats MTI (7).
module csr_irq_arb
    import csr_pkg::*;
(
    input  logic [11:0] pend,
    output logic        irq_valid,
    output logic [3:0]  code
);

    // Only the three architected sources can ever be pending; the rest are ignored
    logic unused_pend;
    assign unused_pend = ^{pend[10:8], pend[6:4], pend[2:0]};

    // Pick the highest-priority pending source
    always_comb begin
        irq_valid = 1'b0;
        code      = 4'd0;
        if (pend[CAUSE_MEI]) begin
            irq_valid = 1'b1;
            code      = CAUSE_MEI;
        end else if (pend[CAUSE_MSI]) begin
            irq_valid = 1'b1;
            code      = CAUSE_MSI;
        end else if (pend[CAUSE_MTI]) begin
            irq_valid = 1'b1;
            code      = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and interrupt controller for the single-issue RV32 core.
// Priority of same-cycle events on shared state: trap > mret > CSR write.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter bit              VECTORED_EN = 1'b1,
    parameter bit              IRQ_SYNC    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      csr_op,
    input  logic            csr_rd,
    input  logic [XLEN-1:0] pc,
    input  logic            inst_valid,
    input  logic            is_mret,
    input  logic            tm_interupt,
    input  logic            ext_interupt,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] epc,
    output logic            epc_taken,
    output logic            excep,
    output logic [XLEN-1:0] trap_pc,
    output logic            in_handler
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // mtvec.MODE is WARL: only direct (0) or, when enabled, vectored (1) is kept
    function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v & ALIGN_MASK;
        if (VECTORED_EN && (v[1:0] == 2'b01)) r[0] = 1'b1;
        return r;
    endfunction

    // Architectural state
    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic [11:0]     mie_q;
    logic            msip_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    csr_state_e      state_q, state_d;

    // Interrupt levels as seen by mip
    logic mtip, meip;

    generate
        if (IRQ_SYNC) begin : g_irq_sync
            logic mtip_q, meip_q;
            // One register stage between the pins and mip
            always_ff @(posedge clk) begin
                if (rst) begin
                    mtip_q <= 1'b0;
                    meip_q <= 1'b0;
                end else begin
                    mtip_q <= tm_interupt;
                    meip_q <= ext_interupt;
                end
            end
            assign mtip = mtip_q;
            assign meip = meip_q;
        end else begin : g_irq_direct
            assign mtip = tm_interupt;
            assign meip = ext_interupt;
        end
    endgenerate

    logic [11:0]     mip_bits;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [11:0]     pend;
    logic            irq_valid;
    logic [3:0]      irq_code;
    logic            wr_en;
    logic            mret_take;
    logic [XLEN-1:0] trap_cause;
    csr_op_e         op;

    assign op       = csr_op_e'(csr_op);
    assign mip_bits = {meip, 3'b000, mtip, 3'b000, msip_q, 3'b000};

    // Visible mstatus: only MIE and MPIE exist
    always_comb begin
        mstatus_val                   = '0;
        mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    end

    // Current value of the addressed CSR; unimplemented addresses read 0
    always_comb begin
        old_val = '0;
        case (addr)
            CSR_MSTATUS:  old_val = mstatus_val;
            CSR_MIE:      old_val = XLEN'(mie_q);
            CSR_MTVEC:    old_val = mtvec_q;
            CSR_MSCRATCH: old_val = mscratch_q;
            CSR_MEPC:     old_val = mepc_q;
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MIP:      old_val = XLEN'(mip_bits);
            default:      old_val = '0;
        endcase
    end

    assign rdata = csr_rd ? old_val : '0;

    // Read-modify-write result before per-register masking
    always_comb begin
        new_val = old_val;
        case (op)
            CSR_OP_RW: new_val = wdata;
            CSR_OP_RS: new_val = old_val | wdata;
            CSR_OP_RC: new_val = old_val & ~wdata;
            default:   new_val = old_val;
        endcase
    end

    // Interrupts are only eligible with global MIE set
    assign pend = mstatus_mie_q ? (mie_q & mip_bits) : 12'd0;

    csr_irq_arb u_irq_arb (
        .pend      (pend),
        .irq_valid (irq_valid),
        .code      (irq_code)
    );

    assign excep      = irq_valid & inst_valid;
    assign mret_take  = is_mret & inst_valid & ~excep;
    assign epc_taken  = mret_take;
    assign epc        = mepc_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign trap_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};

    // A trapped instruction re-executes after mret, so its write must not land;
    // set/clear with a zero mask is architecturally a pure read
    assign wr_en = (op != CSR_OP_NONE) && !excep &&
                   !(((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (wdata == '0));

    // Handler address: base, plus 4*cause in vectored mode
    always_comb begin
        trap_pc = mtvec_q & ALIGN_MASK;
        if (VECTORED_EN && (mtvec_q[1:0] == 2'b01)) begin
            trap_pc = (mtvec_q & ALIGN_MASK) + XLEN'({irq_code, 2'b00});
        end
    end

    // Next FSM state: trap enters (or stays in) HANDLER, mret returns to RUN
    always_comb begin
        state_d = state_q;
        if (excep) begin
            state_d = ST_HANDLER;
        end else if (mret_take) begin
            state_d = ST_RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // mstatus: trap stacking, then mret unstacking, then software writes
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (excep) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_take) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (wr_en && (addr == CSR_MSTATUS)) begin
            mstatus_mie_q  <= new_val[MSTATUS_MIE_BIT];
            mstatus_mpie_q <= new_val[MSTATUS_MPIE_BIT];
        end
    end

    // Remaining CSRs: trap capture of mepc/mcause, otherwise masked software writes
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= '0;
            msip_q     <= 1'b0;
            mtvec_q    <= legal_mtvec(MTVEC_RST);
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (excep) begin
            mepc_q   <= pc & ALIGN_MASK;
            mcause_q <= trap_cause;
        end else if (wr_en) begin
            case (addr)
                CSR_MIE:      mie_q      <= new_val[11:0] & MIE_WMASK[11:0];
                CSR_MTVEC:    mtvec_q    <= legal_mtvec(new_val);
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
                CSR_MCAUSE:   mcause_q   <= new_val;
                CSR_MIP:      msip_q     <= new_val[CAUSE_MSI] & MIP_WMASK[CAUSE_MSI];
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios followed by random traffic,
// all compared against a behavioural model of the CSR/interrupt rules.
module tb_csr_unit;

    localparam int          XLEN      = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  csr_op;
    logic        csr_rd;
    logic [31:0] pc;
    logic        inst_valid;
    logic        is_mret;
    logic        tm_interupt;
    logic        ext_interupt;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        epc_taken;
    logic        excep;
    logic [31:0] trap_pc;
    logic        in_handler;

    int n_checks = 0;
    int n_errors = 0;

    // Clock
    always #5 clk = ~clk;

    csr_unit #(
        .XLEN        (XLEN),
        .MTVEC_RST   (MTVEC_RST),
        .VECTORED_EN (1'b1),
        .IRQ_SYNC    (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .csr_op       (csr_op),
        .csr_rd       (csr_rd),
        .pc           (pc),
        .inst_valid   (inst_valid),
        .is_mret      (is_mret),
        .tm_interupt  (tm_interupt),
        .ext_interupt (ext_interupt),
        .rdata        (rdata),
        .epc          (epc),
        .epc_taken    (epc_taken),
        .excep        (excep),
        .trap_pc      (trap_pc),
        .in_handler   (in_handler)
    );

    // ---------------- reference model ----------------
    bit          m_mie_en, m_mpie, m_msip, m_handler, m_tm_seen, m_ext_seen;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    bit          p_trap, p_mret;
    int          p_code;

    function automatic void model_reset();
        m_mie_en = 0; m_mpie = 0; m_msip = 0; m_handler = 0;
        m_tm_seen = 0; m_ext_seen = 0;
        m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    endfunction

    function automatic logic [31:0] m_mip();
        return (m_ext_seen ? 32'h800 : 32'h0) | (m_tm_seen ? 32'h80 : 32'h0) | (m_msip ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie_en ? 32'h8 : 32'h0);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
            default: return 32'h0;
        endcase
    endfunction

    // Highest-priority enabled cause, or -1
    function automatic int m_cause();
        logic [31:0] p;
        int order[3];
        order = '{11, 3, 7};
        p = m_mie_en ? (m_mie & m_mip()) : 32'h0;
        foreach (order[i]) if (p[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: compare combinational outputs with the model
    task automatic settle();
        int          c;
        logic [31:0] base, exp_tp;
        @(negedge clk);
        c      = m_cause();
        p_trap = inst_valid && (c >= 0);
        p_mret = is_mret && inst_valid && !p_trap;
        p_code = c;
        base   = m_mtvec & ~32'h3;
        exp_tp = base + (((m_mtvec[1:0] == 2'b01) && (c >= 0)) ? 32'(4 * c) : 32'h0);
        check("excep", excep, 32'(p_trap));
        check("trap_pc", trap_pc, exp_tp);
        check("epc_taken", epc_taken, 32'(p_mret));
        check("epc", epc, m_mepc);
        check("in_handler", in_handler, 32'(m_handler));
        check("rdata", rdata, csr_rd ? m_read(addr) : 32'h0);
    endtask

    // Clock edge: apply the architectural rules to the model
    task automatic tick();
        logic [31:0] old, nv;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            old = m_read(addr);
            if (p_trap) begin
                m_mepc    = pc & ~32'h3;
                m_mcause  = 32'h8000_0000 | 32'(p_code);
                m_mpie    = m_mie_en;
                m_mie_en  = 0;
                m_handler = 1;
            end else begin
                if (p_mret) begin
                    m_mie_en  = m_mpie;
                    m_mpie    = 1;
                    m_handler = 0;
                end
                if (csr_op != 2'b00 && !(csr_op != 2'b01 && wdata == 32'h0)) begin
                    nv = (csr_op == 2'b01) ? wdata : (csr_op == 2'b10) ? (old | wdata) : (old & ~wdata);
                    case (addr)
                        12'h300: if (!p_mret) begin m_mie_en = nv[3]; m_mpie = nv[7]; end
                        12'h304: m_mie = nv & 32'h888;
                        12'h305: m_mtvec = (nv & ~32'h3) | ((nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
                        12'h340: m_mscratch = nv;
                        12'h341: m_mepc = nv & ~32'h3;
                        12'h342: m_mcause = nv;
                        12'h344: m_msip = nv[3];
                        default: ;
                    endcase
                end
            end
            m_tm_seen  = tm_interupt;
            m_ext_seen = ext_interupt;
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst = 0; addr = 12'h0; wdata = 32'h0; csr_op = 2'b00; csr_rd = 0;
        pc = 32'h0; inst_valid = 0; is_mret = 0;
    endtask

    task automatic csr_instr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [31:0] p);
        idle();
        csr_op = op; addr = a; wdata = wd; csr_rd = 1; inst_valid = 1; pc = p;
    endtask

    task automatic read_expect(input logic [11:0] a, input logic [31:0] exp, input string tag);
        idle();
        addr = a; csr_rd = 1;
        settle();
        check(tag, rdata, exp);
        tick();
    endtask

    logic [11:0] addrs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h7C0};
        idle();
        tm_interupt = 0; ext_interupt = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        rst = 0;

        // 1: reset values
        read_expect(12'h300, 32'h0, "s1_mstatus");
        read_expect(12'h304, 32'h0, "s1_mie");
        read_expect(12'h305, MTVEC_RST, "s1_mtvec");
        read_expect(12'h340, 32'h0, "s1_mscratch");
        read_expect(12'h341, 32'h0, "s1_mepc");
        read_expect(12'h342, 32'h0, "s1_mcause");
        read_expect(12'h344, 32'h0, "s1_mip");
        check("s1_excep", excep, 32'h0);
        check("s1_in_handler", in_handler, 32'h0);
        check("s1_trap_pc", trap_pc, MTVEC_RST);

        // 2: timer interrupt, vectored mtvec
        csr_instr(2'b01, 12'h305, 32'h0000_1001, 32'h10); cycle();
        csr_instr(2'b10, 12'h304, 32'h80, 32'h14); cycle();
        csr_instr(2'b10, 12'h300, 32'h8, 32'h18); cycle();
        idle(); tm_interupt = 1; pc = 32'h40; inst_valid = 1;
        settle(); check("s2_sync_delay", excep, 32'h0); tick();
        settle(); check("s2_excep", excep, 32'h1); check("s2_trap_pc", trap_pc, 32'h101C); tick();
        read_expect(12'h341, 32'h40, "s2_mepc");
        read_expect(12'h342, 32'h8000_0007, "s2_mcause");
        read_expect(12'h300, 32'h80, "s2_mstatus");
        check("s2_in_handler", in_handler, 32'h1);

        // 3: mret
        idle(); is_mret = 1; inst_valid = 1; pc = 32'h1010;
        settle(); check("s3_epc_taken", epc_taken, 32'h1); check("s3_epc", epc, 32'h40); tick();
        read_expect(12'h300, 32'h88, "s3_mstatus");
        check("s3_in_handler", in_handler, 32'h0);
        tm_interupt = 0; idle(); cycle(); cycle();

        // 4: external beats timer; trapped MSIP write is dropped
        csr_instr(2'b01, 12'h304, 32'h888, 32'h20); cycle();
        idle(); ext_interupt = 1; tm_interupt = 1; cycle();
        csr_instr(2'b10, 12'h344, 32'h8, 32'h80);
        settle(); check("s4_excep", excep, 32'h1); check("s4_trap_pc", trap_pc, 32'h102C); tick();
        read_expect(12'h342, 32'h8000_000B, "s4_mcause");
        read_expect(12'h344, 32'h880, "s4_mip");
        read_expect(12'h341, 32'h80, "s4_mepc");
        idle(); is_mret = 1; inst_valid = 1; cycle();
        ext_interupt = 0; tm_interupt = 0; idle(); cycle(); cycle();

        // 5: trap wins over csrrc of mstatus
        idle(); ext_interupt = 1; cycle();
        csr_instr(2'b11, 12'h300, 32'h8, 32'hC4);
        settle(); check("s5_excep", excep, 32'h1); tick();
        read_expect(12'h300, 32'h80, "s5_mstatus");
        read_expect(12'h341, 32'hC4, "s5_mepc");

        // 6: reset while in HANDLER with interrupts held high
        tm_interupt = 1;
        idle(); rst = 1; cycle();
        idle(); inst_valid = 1;
        settle(); check("s6_in_handler", in_handler, 32'h0); check("s6_excep", excep, 32'h0); tick();
        read_expect(12'h300, 32'h0, "s6_mstatus");
        read_expect(12'h341, 32'h0, "s6_mepc");
        read_expect(12'h305, MTVEC_RST, "s6_mtvec");
        tm_interupt = 0; ext_interupt = 0;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            idle();
            addr   = addrs[$urandom_range(0, 7)];
            csr_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)      wdata = 32'h0;
            else if ($urandom_range(0, 1) == 1) wdata = $urandom;
            else                                wdata = (32'h888 & $urandom) | 32'($urandom_range(0, 3));
            csr_rd     = 1'($urandom_range(0, 1));
            pc         = $urandom;
            inst_valid = ($urandom_range(0, 3) != 0);
            is_mret    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) tm_interupt  = ~tm_interupt;
            if ($urandom_range(0, 7) == 0) ext_interupt = ~ext_interupt;
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
